// File: rtl/mem_copy_engine_if.sv
// Command and memory-bus signals of the copy/fill engine.
// The master modport is the command/memory side; the slave modport is the engine itself.
interface mem_copy_engine_if #(parameter int LW = 6);
    logic          Start;
    logic          Mode;
    logic [31:0]   Src;
    logic [31:0]   Dst;
    logic [LW-1:0] Len;
    logic [31:0]   FillVal;
    logic [31:0]   MemRdata;
    logic [31:0]   MemAddr;
    logic [31:0]   MemWdata;
    logic          MemWe;
    logic          Busy;
    logic          Done;

    modport master (
        output Start, Mode, Src, Dst, Len, FillVal, MemRdata,
        input  MemAddr, MemWdata, MemWe, Busy, Done
    );

    modport slave (
        input  Start, Mode, Src, Dst, Len, FillVal, MemRdata,
        output MemAddr, MemWdata, MemWe, Busy, Done
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Small DMA engine: copies Len words Src->Dst (READ/WRITE pairs) or fills Len words at Dst.
// Memory outputs are decoded from state registers only, so there is no input-to-output path.
module mem_copy_engine #(
    parameter int LW = 6
) (
    input logic              Clk,
    input logic              Rst,
    mem_copy_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t        state;
    logic          mode;
    logic [31:0]   src;
    logic [31:0]   dst;
    logic [31:0]   fill;
    logic [31:0]   rbuf;
    logic [LW-1:0] len;
    logic [LW-1:0] idx;
    logic [LW:0]   idx_nx;
    logic          last;

    // One extra bit so the compare against len cannot alias on overflow.
    assign idx_nx = {1'b0, idx} + 1'b1;
    assign last   = (idx_nx == {1'b0, len});

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
            mode  <= 1'b0;
            src   <= '0;
            dst   <= '0;
            fill  <= '0;
            rbuf  <= '0;
            len   <= '0;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        mode <= bus.Mode;
                        src  <= bus.Src;
                        dst  <= bus.Dst;
                        len  <= bus.Len;
                        fill <= bus.FillVal;
                        idx  <= '0;
                        if (bus.Len == '0)  state <= DONE;
                        else if (bus.Mode)  state <= WRITE;
                        else                state <= READ;
                    end
                end
                READ: begin
                    rbuf  <= bus.MemRdata;
                    state <= WRITE;
                end
                WRITE: begin
                    idx <= idx_nx[LW-1:0];
                    if (last)      state <= DONE;
                    else if (mode) state <= WRITE;
                    else           state <= READ;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Busy = (state != IDLE);
    assign bus.Done = (state == DONE);

    always_comb begin
        bus.MemAddr  = '0;
        bus.MemWdata = '0;
        bus.MemWe    = 1'b0;
        case (state)
            READ: bus.MemAddr = src + 32'(idx);
            WRITE: begin
                bus.MemAddr  = dst + 32'(idx);
                bus.MemWdata = mode ? fill : rbuf;
                bus.MemWe    = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench: a word-level model predicts every bus read/write and the final memory image.
module tb_mem_copy_engine;
    localparam int LW = 6;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    mem_copy_engine_if #(.LW(LW)) bus();
    mem_copy_engine #(.LW(LW)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

    // 32-word memory: combinational read, write on the rising edge; ld is a bench preload port.
    logic [31:0] mem [32];
    logic [31:0] ref_mem [32];
    logic        ld = 1'b0;
    logic [4:0]  ld_a = '0;
    logic [31:0] ld_d = '0;
    assign bus.MemRdata = mem[bus.MemAddr[4:0]];
    always @(posedge Clk) begin
        if (bus.MemWe)  mem[bus.MemAddr[4:0]] <= bus.MemWdata;
        else if (ld)    mem[ld_a] <= ld_d;
    end

    logic [31:0] exp_ra[$];
    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(input int a, input logic [31:0] d);
        @(negedge Clk);
        ld = 1'b1; ld_a = a[4:0]; ld_d = d;
        @(posedge Clk);
        #1 ld = 1'b0;
        ref_mem[a[4:0]] = d;
    endtask

    // Word-by-word reference: read index i then write index i, ascending, addresses mod 32.
    task automatic model(input bit md, input logic [31:0] s, input logic [31:0] d, input int n,
                         input logic [31:0] f, input int rd_lim, input int wr_lim);
        logic [31:0] v;
        for (int i = 0; i < n; i++) begin
            if (!md && i < rd_lim) exp_ra.push_back(s + i);
            if (i < wr_lim) begin
                v = md ? f : ref_mem[(s + i) % 32];
                exp_wa.push_back(d + i);
                exp_wd.push_back(v);
                ref_mem[(d + i) % 32] = v;
            end
        end
    endtask

    task automatic drive(input bit md, input logic [31:0] s, input logic [31:0] d, input int n,
                         input logic [31:0] f);
        logic [31:0] nn;
        nn = n;
        bus.Start = 1'b1; bus.Mode = md; bus.Src = s; bus.Dst = d;
        bus.Len = nn[LW-1:0]; bus.FillVal = f;
    endtask

    // Called right after the accepting edge; checks Done/Busy/MemWe timing by cycle number.
    task automatic wait_done(input bit md, input int n, input string nm);
        logic [63:0] we_m, busy_m, exp_we, exp_busy;
        int c, dc, dexp;
        dexp = (n == 0) ? 1 : (md ? n + 1 : 2 * n + 1);
        exp_we = '0; exp_busy = '0; we_m = '0; busy_m = '0;
        for (int k = 1; k <= dexp; k++) exp_busy[k] = 1'b1;
        for (int k = 1; k <= n; k++) begin
            if (md) exp_we[k] = 1'b1;
            else    exp_we[2*k] = 1'b1;
        end
        c = 0; dc = 0;
        while (dc == 0 && c < 150) begin
            @(negedge Clk);
            c++;
            if (c < 64) begin
                we_m[c] = bus.MemWe;
                busy_m[c] = bus.Busy;
            end
            if (bus.Done) dc = c;
        end
        chk({nm, " done_cycle"}, 64'(dc), 64'(dexp));
        chk({nm, " we_cycles"}, we_m, exp_we);
        chk({nm, " busy_cycles"}, busy_m, exp_busy);
        @(negedge Clk);
        chk({nm, " idle_after"}, {61'd0, bus.Busy, bus.Done, bus.MemWe}, 64'd0);
    endtask

    task automatic run(input bit md, input logic [31:0] s, input logic [31:0] d, input int n,
                       input logic [31:0] f, input string nm);
        @(negedge Clk);
        drive(md, s, d, n, f);
        model(md, s, d, n, f, 64, 64);
        @(posedge Clk);
        #1 bus.Start = 1'b0;
        wait_done(md, n, nm);
    endtask

    // Monitor: every READ/WRITE cycle the DUT presents is matched against the model queues.
    initial begin : monitor
        logic [31:0] a, d;
        forever begin
            @(negedge Clk);
            if (!Rst) begin
                if (bus.MemWe) begin
                    if (exp_wa.size() == 0) chk("unexpected write", {32'd0, bus.MemAddr}, 64'hFFFF_FFFF_FFFF_FFFF);
                    else begin
                        a = exp_wa.pop_front();
                        d = exp_wd.pop_front();
                        chk("wr_addr", {32'd0, bus.MemAddr}, {32'd0, a});
                        chk("wr_data", {32'd0, bus.MemWdata}, {32'd0, d});
                    end
                end else if (bus.Busy && !bus.Done) begin
                    if (exp_ra.size() == 0) chk("unexpected read", {32'd0, bus.MemAddr}, 64'hFFFF_FFFF_FFFF_FFFF);
                    else begin
                        a = exp_ra.pop_front();
                        chk("rd_addr", {32'd0, bus.MemAddr}, {32'd0, a});
                    end
                end else if (bus.Done) begin
                    chk("done_bus_idle", {bus.MemAddr, bus.MemWdata}, 64'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] w31, w0;
        int bad;
        bus.Start = 1'b0; bus.Mode = 1'b0; bus.Src = '0; bus.Dst = '0;
        bus.Len = '0; bus.FillVal = '0;
        for (int i = 0; i < 32; i++) load(i, $urandom);
        #1;
        chk("reset_outputs", {bus.MemAddr, bus.MemWdata[29:0], bus.MemWe, bus.Busy},
            64'd0);
        chk("reset_done", {63'd0, bus.Done}, 64'd0);
        @(negedge Clk) Rst = 1'b0;

        // Directed copy: words 1,2 -> 8,9
        load(1, 32'd3);
        load(2, 32'd4);
        run(1'b0, 32'd1, 32'd8, 2, 32'd0, "copy2");
        chk("copy2 word8", {32'd0, mem[8]}, 64'd3);
        chk("copy2 word9", {32'd0, mem[9]}, 64'd4);

        // Fill wrapping past word 31
        run(1'b1, 32'd0, 32'd30, 4, 32'hDEADBEEF, "fill4");
        chk("fill word30", {32'd0, mem[30]}, 64'hDEADBEEF);
        chk("fill word31", {32'd0, mem[31]}, 64'hDEADBEEF);
        chk("fill word0",  {32'd0, mem[0]},  64'hDEADBEEF);
        chk("fill word1",  {32'd0, mem[1]},  64'hDEADBEEF);

        // Zero-length in both modes
        run(1'b0, 32'd3, 32'd12, 0, 32'd0, "len0_copy");
        run(1'b1, 32'd3, 32'd12, 0, 32'h1234, "len0_fill");

        // Start held high: second command accepted only at the edge after DONE
        @(negedge Clk);
        drive(1'b0, 32'd16, 32'd24, 3, 32'd0);
        model(1'b0, 32'd16, 32'd24, 3, 32'd0, 64, 64);
        model(1'b1, 32'd0, 32'd5, 2, 32'hA5A5_0F0F, 64, 64);
        @(posedge Clk);
        #1 drive(1'b1, 32'd0, 32'd5, 2, 32'hA5A5_0F0F);
        wait_done(1'b0, 3, "hold_first");
        @(posedge Clk);
        #1 bus.Start = 1'b0;
        wait_done(1'b1, 2, "hold_second");

        // Reset during the second WRITE of a 3-word copy
        @(negedge Clk);
        drive(1'b0, 32'd10, 32'd20, 3, 32'd0);
        model(1'b0, 32'd10, 32'd20, 3, 32'd0, 2, 1);
        @(posedge Clk);
        #1 bus.Start = 1'b0;
        repeat (3) @(posedge Clk);
        #1 chk("rst we_before", {63'd0, bus.MemWe}, 64'd1);
        #1 Rst = 1'b1;
        #1 chk("rst outputs_dropped", {bus.MemAddr, 29'd0, bus.MemWe, bus.Busy, bus.Done}, 64'd0);
        @(negedge Clk) Rst = 1'b0;
        chk("rst word20", {32'd0, mem[20]}, {32'd0, ref_mem[20]});
        chk("rst word21", {32'd0, mem[21]}, {32'd0, ref_mem[21]});
        run(1'b0, 32'd20, 32'd26, 2, 32'd0, "after_rst");

        // Source address wrapping past 0xFFFFFFFF
        w31 = $urandom; w0 = $urandom;
        load(31, w31);
        load(0, w0);
        run(1'b0, 32'hFFFF_FFFF, 32'd4, 2, 32'd0, "wrap_copy");
        chk("wrap word4", {32'd0, mem[4]}, {32'd0, w31});
        chk("wrap word5", {32'd0, mem[5]}, {32'd0, w0});

        // Randomized commands, overlapping regions included
        for (int t = 0; t < 20; t++)
            run(1'(($urandom_range(0, 1))), $urandom, $urandom, $urandom_range(0, 31), $urandom,
                "random");

        repeat (2) @(negedge Clk);
        chk("queues_drained", 64'(exp_wa.size() + exp_ra.size()), 64'd0);
        bad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("final_memory_words_wrong", 64'(bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Bus-initiator block that drives the 32-word data memory's address/write port (Addr, Din, We; combinational read data back). On a Start command it either copies Len consecutive words from Src to Dst or fills Len words at Dst with a constant, one word at a time. The block sits beside the CPU datapath as a small DMA engine; a top-level mux selects it or the CPU as memory master while Busy is high.

## Interface
- LW, default 6: width of Len; maximum transfer is 2^LW − 1 words.
- Clk  in  1  clock; all state changes on the rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- Start  in  1  command strobe; sampled only in IDLE.
- Mode  in  1  0 = copy, 1 = fill; latched with Start.
- Src  in  32  source word address for copy; latched with Start.
- Dst  in  32  destination word address; latched with Start.
- Len  in  LW  word count; latched with Start.
- FillVal  in  32  fill data for Mode = 1; latched with Start.
- MemRdata  in  32  memory read data (memory Dout, combinational from MemAddr).
- MemAddr  out  32  memory address (memory Addr).
- MemWdata  out  32  memory write data (memory Din).
- MemWe  out  1  memory write enable (memory We).
- Busy  out  1  high from the cycle after Start is accepted through the DONE cycle.
- Done  out  1  one-cycle pulse when the transfer completes.

## Operation
- States: IDLE, READ, WRITE, DONE. Registers: mode, src, dst, len, fill, idx (LW bits), buf (32 bits).
- IDLE: if Start, latch Mode/Src/Dst/Len/FillVal and set idx = 0. Next state is DONE if Len == 0, WRITE if Mode == 1, otherwise READ. Start is ignored in every other state.
- READ: MemAddr = src + idx, MemWe = 0. buf <= MemRdata at the edge. Next state is WRITE.
- WRITE: MemAddr = dst + idx. MemWdata = buf (copy) or fill (fill). MemWe = 1. idx <= idx + 1. Next state:
  - DONE if idx + 1 == len;
  - else READ for copy;
  - else WRITE for fill.
- DONE: Done = 1, Busy = 1, MemWe = 0. Next state is IDLE.
- Address arithmetic is 32-bit modulo 2^32; wrap-around past 0xFFFFFFFF is legal. The memory decodes only Addr[4:0], so transfers wrap modulo 32 words.
- Overlapping Src/Dst regions are not detected. Copy order is ascending, so each word is read before the same-index write.
- Outputs in IDLE and DONE: MemAddr = 0, MemWdata = 0, MemWe = 0.
- MemWe, MemAddr and MemWdata are decoded combinationally from the state registers and contain no combinational path from inputs. MemRdata feeds only buf.

## Timing
- Reset values: state = IDLE; Busy = 0, Done = 0, MemWe = 0, MemAddr = 0, MemWdata = 0; all internal registers = 0.
- Reset mid-transfer: all outputs go to reset values immediately, asynchronously. No further writes occur. Words already written stay written.
- Copy of N ≥ 1 words: Start accepted at edge 0. READ/WRITE pairs occupy cycles 1 .. 2N. DONE occupies cycle 2N+1. IDLE is reached at edge 2N+2, and a new Start is accepted on that edge or later.
- Fill of N ≥ 1 words: WRITE occupies cycles 1 .. N; DONE occupies cycle N+1.
- Len = 0: DONE occupies cycle 1; no memory access.
- Each memory write commits on the rising edge that ends its WRITE cycle.

## Test plan
- Reset, then copy with Src = 1, Dst = 8, Len = 2, memory preloaded word1 = 3, word2 = 4:
  - MemWe is high only in cycles 2 and 4;
  - afterwards word8 = 3, word9 = 4;
  - Done pulses once in cycle 5;
  - Busy is high for cycles 1–5.
- Fill with Dst = 30, Len = 4, FillVal = 0xDEADBEEF:
  - words 30, 31, 0 and 1 (modulo-32 wrap) = 0xDEADBEEF;
  - MemWe is high in cycles 1–4;
  - Done pulses in cycle 5.
- Len = 0, with Start on both modes: Done pulses in cycle 1, MemWe never asserts, memory is unchanged.
- Start re-asserted continuously during a Len = 3 copy: the second command is accepted only at the edge after DONE, and the first transfer's values are unaffected.
- Rst asserted asynchronously during the second WRITE of a Len = 3 copy:
  - MemWe/Busy drop before the next edge;
  - exactly one destination word has been written;
  - a fresh transfer after reset completes correctly.
- Src = 0xFFFFFFFF, Dst = 4, Len = 2 copy: reads addresses 0xFFFFFFFF then 0x00000000 (words 31 and 0), writing them to words 4 and 5.
